// File: rtl/image_blit_engine.sv
// rtl/image_blit_engine.sv - scaled sprite blitter: ROM source, integer upscale, clip and colour key.
module image_blit_engine #(
   parameter int SRC_W       = 160,
   parameter int SRC_H       = 120,
   parameter int SCALE_LOG2  = 2,
   parameter int COLOR_W     = 9,
   parameter int ROM_LATENCY = 1,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int ADDR_W      = 15
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   input  logic [9:0]         dst_x,
   input  logic [8:0]         dst_y,
   input  logic               key_en,
   input  logic [COLOR_W-1:0] key_color,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_q,
   output logic [9:0]         vga_x,
   output logic [8:0]         vga_y,
   output logic [COLOR_W-1:0] vga_color,
   output logic               vga_write,
   output logic               busy,
   output logic               done
);

   localparam int OUT_W = SRC_W << SCALE_LOG2;
   localparam int OUT_H = SRC_H << SCALE_LOG2;
   localparam int SX_W  = (OUT_W > 2) ? $clog2(OUT_W) : 1;
   localparam int SY_W  = (OUT_H > 2) ? $clog2(OUT_H) : 1;
   localparam int L     = ROM_LATENCY;

   localparam logic [SX_W-1:0] SX_LAST = SX_W'(OUT_W - 1);
   localparam logic [SY_W-1:0] SY_LAST = SY_W'(OUT_H - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]         state;
   logic [SX_W-1:0]    sx;
   logic [SY_W-1:0]    sy;
   logic [9:0]         dst_x_q;
   logic [8:0]         dst_y_q;
   logic               key_en_q;
   logic [COLOR_W-1:0] key_color_q;

   // Coordinates travel one bit wider than the screen so clipping never wraps.
   logic [L-1:0]       pv;
   logic [10:0]        px [L];
   logic [9:0]         py [L];

   logic [10:0]        sum_x;
   logic [9:0]         sum_y;
   logic               pix_write;

   assign busy  = (state != IDLE);
   assign sum_x = 11'(dst_x_q) + 11'(sx);
   assign sum_y = 10'(dst_y_q) + 10'(sy);

   assign rom_addr = resetn
      ? ADDR_W'(32'(sy >> SCALE_LOG2) * 32'(SRC_W) + 32'(sx >> SCALE_LOG2))
      : '0;

   assign pix_write = pv[L-1]
                   && !(key_en_q && (rom_q == key_color_q))
                   && (px[L-1] < 11'(SCREEN_W))
                   && (py[L-1] < 10'(SCREEN_H));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         sx          <= '0;
         sy          <= '0;
         dst_x_q     <= '0;
         dst_y_q     <= '0;
         key_en_q    <= 1'b0;
         key_color_q <= '0;
         pv          <= '0;
         for (int i = 0; i < L; i++) begin
            px[i] <= '0;
            py[i] <= '0;
         end
         vga_x       <= '0;
         vga_y       <= '0;
         vga_color   <= '0;
         vga_write   <= 1'b0;
         done        <= 1'b0;
      end else begin
         done      <= 1'b0;
         vga_write <= 1'b0;

         if (pv[L-1]) begin
            vga_x     <= px[L-1][9:0];
            vga_y     <= py[L-1][8:0];
            vga_color <= rom_q;
            vga_write <= pix_write;
         end

         pv[0] <= (state == RUN);
         px[0] <= sum_x;
         py[0] <= sum_y;
         for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            px[i] <= px[i-1];
            py[i] <= py[i-1];
         end

         case (state)
            IDLE: begin
               if (start && !abort) begin
                  dst_x_q     <= dst_x;
                  dst_y_q     <= dst_y;
                  key_en_q    <= key_en;
                  key_color_q <= key_color;
                  sx          <= '0;
                  sy          <= '0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (sx == SX_LAST) begin
                  sx <= '0;
                  if (sy == SY_LAST) state <= DRAIN;
                  else               sy    <= sy + SY_W'(1);
               end else begin
                  sx <= sx + SX_W'(1);
               end
            end
            DRAIN: begin
               if (pv == '0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Abort wins over everything above: drop in-flight pixels and the done pulse.
         if (abort && (state != IDLE)) begin
            state     <= IDLE;
            pv        <= '0;
            vga_write <= 1'b0;
            done      <= 1'b0;
         end
      end
   end

endmodule
